// File: rtl/sim_reset_sequencer.sv
// Staged multi-domain reset sequencer: releases NUM_DOM reset domains in order,
// each gated by the previous domain's ready plus a gap, with a per-stage timeout watchdog.
module sim_reset_sequencer #(
    parameter int NUM_DOM     = 3,
    parameter int HOLD_CYCLES = 10,
    parameter int STAGE_GAP   = 4,
    parameter int TIMEOUT     = 65535,
    parameter int IDX_W       = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_retrigger,
    input  logic [NUM_DOM-1:0] i_ready,
    output logic [NUM_DOM-1:0] o_rst,
    output logic [NUM_DOM-1:0] o_rst_n,
    output logic               o_all_ready,
    output logic               o_timeout,
    output logic [IDX_W-1:0]   o_fail_idx
);

    localparam logic [2:0] ST_HOLD  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_GAP   = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam int MAX_HG   = (HOLD_EFF > STAGE_GAP) ? HOLD_EFF : STAGE_GAP;
    localparam int CNT_MAX  = (MAX_HG > TIMEOUT) ? MAX_HG : TIMEOUT;
    localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_EFF - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_DOM-1:0] rst_q, rst_d;
    logic               all_rdy_q, all_rdy_d;
    logic               timeout_q, timeout_d;
    logic [IDX_W-1:0]   fail_idx_q, fail_idx_d;

    logic               ready_cur_s;
    logic [NUM_DOM-1:0] rel_mask_s;
    logic [IDX_W-1:0]   idx_next_s;

    assign idx_next_s = idx_q + IDX_W'(1);

    // Ready bit of the stage being waited on, and the mask that releases the next domain.
    always_comb begin
        ready_cur_s = 1'b0;
        rel_mask_s  = '1;
        for (int k = 0; k < NUM_DOM; k++) begin
            if (idx_q == IDX_W'(k)) begin
                ready_cur_s = i_ready[k];
            end else begin
                ready_cur_s = ready_cur_s;
            end
            if (idx_next_s == IDX_W'(k)) begin
                rel_mask_s[k] = 1'b0;
            end else begin
                rel_mask_s[k] = 1'b1;
            end
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rst_d      = rst_q;
        all_rdy_d  = all_rdy_q;
        timeout_d  = timeout_q;
        fail_idx_d = fail_idx_q;
        if (i_retrigger) begin
            state_d    = ST_HOLD;
            cnt_d      = '0;
            idx_d      = '0;
            rst_d      = '1;
            all_rdy_d  = 1'b0;
            timeout_d  = 1'b0;
            fail_idx_d = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        rst_d[0] = 1'b0;
                        cnt_d    = '0;
                        idx_d    = '0;
                        state_d  = ST_WAIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (ready_cur_s) begin
                        if (idx_q == IDX_LAST) begin
                            state_d   = ST_DONE;
                            all_rdy_d = 1'b1;
                        end else if (STAGE_GAP == 0) begin
                            // Zero gap: release the next domain on the same edge ready is seen.
                            rst_d   = rst_q & rel_mask_s;
                            idx_d   = idx_next_s;
                            cnt_d   = '0;
                            state_d = ST_WAIT;
                        end else begin
                            cnt_d   = '0;
                            state_d = ST_GAP;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        state_d    = ST_FAULT;
                        timeout_d  = 1'b1;
                        fail_idx_d = idx_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        rst_d   = rst_q & rel_mask_s;
                        idx_d   = idx_next_s;
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    all_rdy_d = &i_ready;
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    // Unreachable encoding: fall back to a full, safe restart.
                    state_d    = ST_HOLD;
                    cnt_d      = '0;
                    idx_d      = '0;
                    rst_d      = '1;
                    all_rdy_d  = 1'b0;
                    timeout_d  = 1'b0;
                    fail_idx_d = '0;
                end
            endcase
        end
    end

    // State and output registers; i_rst overrides everything.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q    <= ST_HOLD;
            cnt_q      <= '0;
            idx_q      <= '0;
            rst_q      <= '1;
            all_rdy_q  <= 1'b0;
            timeout_q  <= 1'b0;
            fail_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rst_q      <= rst_d;
            all_rdy_q  <= all_rdy_d;
            timeout_q  <= timeout_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    assign o_rst       = rst_q;
    assign o_rst_n     = ~rst_q;
    assign o_all_ready = all_rdy_q;
    assign o_timeout   = timeout_q;
    assign o_fail_idx  = fail_idx_q;

endmodule
